// File: rtl/counter_scheduler_pkg.sv
// Shared types and helpers for the counter scheduler: FSM state encoding and
// extraction of one requester's length from the packed length bus.
package counter_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Widest supported packed length bus and per-requester length.
  localparam int unsigned LEN_FLAT_W = 1024;
  localparam int unsigned LEN_MAX_W  = 32;

  function automatic logic [LEN_MAX_W-1:0] len_slice(
    input logic [LEN_FLAT_W-1:0] len_flat,
    input int unsigned           n,
    input int unsigned           i
  );
    logic [LEN_FLAT_W-1:0] shifted;
    shifted = len_flat >> (i * n);
    return shifted[LEN_MAX_W-1:0] & ((LEN_MAX_W'(1) << n) - LEN_MAX_W'(1));
  endfunction

endpackage

// File: rtl/counter_scheduler_if.sv
// Request/grant bundle between the client blocks and the counter scheduler.
interface counter_scheduler_if #(
  parameter int N = 8,
  parameter int R = 4
);
  logic [R-1:0]   req;
  logic [R*N-1:0] len;
  logic           abort;
  logic [R-1:0]   gnt;
  logic [R-1:0]   done;
  logic           aborted;
  logic           busy;
  logic [N-1:0]   cnt;

  modport master (
    output req, len, abort,
    input  gnt, done, aborted, busy, cnt
  );

  modport slave (
    input  req, len, abort,
    output gnt, done, aborted, busy, cnt
  );
endinterface

// File: rtl/counter_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i,
// searching upward modulo R.
module rr_arbiter #(
  parameter int R  = 4,
  parameter int IW = (R > 1) ? $clog2(R) : 1
) (
  input  logic [R-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [R-1:0]  win_o,
  output logic [IW-1:0] win_idx_o
);

  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    win_o     = '0;
    win_idx_o = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < R; k++) begin
      idx = IW'((int'(ptr_i) + k) % R);
      if (!found && req_i[idx]) begin
        win_o[idx] = 1'b1;
        win_idx_o  = idx;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_scheduler.sv
// Shares one interval counter among R requesters: round-robin grant, timed
// run of the winner's length, then a four-phase done handshake.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no grant; arbitrate among pending requests
//   RUN     | counting the winner's interval, cnt = 0 .. len-1
//   DONE    | done/gnt held until the winner drops its request
module counter_scheduler
  import counter_scheduler_pkg::*;
#(
  parameter int N = 8,
  parameter int R = 4
) (
  input logic                clk,
  input logic                rst_n,
  counter_scheduler_if.slave bus
);

  localparam int IW = (R > 1) ? $clog2(R) : 1;

  state_e                state_q, state_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [IW-1:0]         w_q, w_d;
  logic [N-1:0]          rem_q, rem_d;
  logic [N-1:0]          cnt_q, cnt_d;
  logic [R-1:0]          gnt_q, gnt_d;
  logic [R-1:0]          done_q, done_d;
  logic                  aborted_q, aborted_d;
  logic                  busy_q, busy_d;

  logic [R-1:0]          win;
  logic [IW-1:0]         win_idx;
  logic [N-1:0]          win_len;
  logic [LEN_FLAT_W-1:0] len_flat;
  logic                  any_req;
  logic                  req_w;
  logic                  stop_early;
  logic                  term_cnt;

  rr_arbiter #(
    .R  (R),
    .IW (IW)
  ) u_arb (
    .req_i     (bus.req),
    .ptr_i     (ptr_q),
    .win_o     (win),
    .win_idx_o (win_idx)
  );

  assign len_flat   = LEN_FLAT_W'(bus.len);
  assign win_len    = N'(len_slice(len_flat, N, 32'(win_idx)));
  assign any_req    = |bus.req;
  assign req_w      = bus.req[w_q];
  assign stop_early = bus.abort | ~req_w;
  // rem_q holds the cycles still to run after the current one
  assign term_cnt   = (rem_q == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      w_q       <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      aborted_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      w_q       <= w_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (any_req) state_d = (win_len == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (stop_early || term_cnt) state_d = ST_DONE;
      ST_DONE: if (!req_w) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ptr_d     = ptr_q;
    w_d       = w_q;
    rem_d     = rem_q;
    cnt_d     = '0;
    gnt_d     = gnt_q;
    done_d    = done_q;
    aborted_d = aborted_q;
    busy_d    = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          w_d       = win_idx;
          rem_d     = win_len - 1'b1;
          gnt_d     = win;
          done_d    = (win_len == '0) ? win : '0;
          aborted_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (state_d == ST_RUN) begin
          cnt_d = cnt_q + 1'b1;
          rem_d = rem_q - 1'b1;
        end else begin
          // abort and withdrawal both outrank a simultaneous normal finish
          done_d    = gnt_q;
          aborted_d = stop_early;
        end
      end
      ST_DONE: begin
        if (state_d == ST_IDLE) begin
          gnt_d     = '0;
          done_d    = '0;
          aborted_d = 1'b0;
          ptr_d     = (w_q == IW'(R - 1)) ? '0 : w_q + 1'b1;
        end
      end
      default: begin
        gnt_d     = '0;
        done_d    = '0;
        aborted_d = 1'b0;
      end
    endcase
  end

  assign bus.gnt     = gnt_q;
  assign bus.done    = done_q;
  assign bus.aborted = aborted_q;
  assign bus.busy    = busy_q;
  assign bus.cnt     = cnt_q;

endmodule

// File: tb/tb_counter_scheduler.sv
// Directed and randomized checks of counter_scheduler against a transaction
// level model of grant order, interval length and handshake timing.
module tb_counter_scheduler;

  localparam int N = 8;
  localparam int R = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  counter_scheduler_if #(.N(N), .R(R)) bus ();

  counter_scheduler #(.N(N), .R(R)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int ptr_m = 0;
  int len_arr [R];
  logic [R-1:0] hist [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic repack();
    for (int i = 0; i < R; i++) bus.len[i*N +: N] = N'(len_arr[i]);
  endtask

  function automatic int model_winner(input logic [R-1:0] r, input int p);
    for (int k = 0; k < R; k++) begin
      int i;
      i = (p + k) % R;
      if (((r >> i) & R'(1)) != '0) return i;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    check("rst_gnt",     32'(bus.gnt),     32'd0);
    check("rst_done",    32'(bus.done),    32'd0);
    check("rst_aborted", 32'(bus.aborted), 32'd0);
    check("rst_busy",    32'(bus.busy),    32'd0);
    check("rst_cnt",     32'(bus.cnt),     32'd0);
    rst_n     = 1'b1;
    bus.req   = '0;
    bus.abort = 1'b0;
    ptr_m     = 0;
  endtask

  // mode: 0 run to completion, 1 abort when cnt==at, 2 withdraw when cnt==at
  task automatic txn(input logic [R-1:0] add, input int mode, input int at,
                     input bit stir, input int hold);
    int w, len_l, end_c;
    logic [R-1:0] base, wm;
    logic [31:0] exp_ab;
    if ((bus.req | add) == '0) add = R'(1) << $urandom_range(0, R-1);
    bus.req = bus.req | add;
    base  = bus.req;
    w     = model_winner(base, ptr_m);
    wm    = R'(1) << w;
    len_l = len_arr[w];
    if (len_l == 0) mode = 0;
    if (mode != 0 && at >= len_l) at = len_l - 1;
    end_c  = (len_l == 0) ? 1 : ((mode == 0) ? len_l + 1 : at + 2);
    exp_ab = (mode != 0) ? 32'd1 : 32'd0;
    for (int c = 1; c <= end_c; c++) begin
      tick();
      bus.abort = 1'b0;
      if (c == 1) hist.push_back(bus.gnt);
      if (c < end_c) begin
        check("run_gnt",  32'(bus.gnt),  32'(wm));
        check("run_cnt",  32'(bus.cnt),  32'(c - 1));
        check("run_done", 32'(bus.done), 32'd0);
        check("run_busy", 32'(bus.busy), 32'd1);
        if (stir) begin
          bus.req = (base & wm) | (R'($urandom) & ~wm);
          for (int i = 0; i < R; i++) len_arr[i] = $urandom_range(0, 12);
          repack();
        end
        if (mode == 1 && c - 1 == at) bus.abort = 1'b1;
        if (mode == 2 && c - 1 == at) bus.req = bus.req & ~wm;
      end
    end
    check("end_done",    32'(bus.done),    32'(wm));
    check("end_gnt",     32'(bus.gnt),     32'(wm));
    check("end_aborted", 32'(bus.aborted), exp_ab);
    check("end_cnt",     32'(bus.cnt),     32'd0);
    bus.req = (mode == 2) ? (base & ~wm) : base;
    if (mode != 2) begin
      for (int h = 0; h < hold; h++) begin
        bus.abort = 1'($urandom_range(0, 1));
        tick();
        check("hold_done",    32'(bus.done),    32'(wm));
        check("hold_aborted", 32'(bus.aborted), exp_ab);
      end
      bus.abort = 1'b0;
      bus.req   = bus.req & ~wm;
    end
    tick();
    check("fall_done",    32'(bus.done),    32'd0);
    check("fall_gnt",     32'(bus.gnt),     32'd0);
    check("fall_busy",    32'(bus.busy),    32'd0);
    check("fall_aborted", 32'(bus.aborted), 32'd0);
    ptr_m = (w + 1) % R;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.req   = '0;
    bus.abort = 1'b0;
    for (int i = 0; i < R; i++) len_arr[i] = 3;
    repack();
    do_reset();

    // single request, then ptr must have moved past requester 2
    len_arr[2] = 5; repack();
    txn(4'b0100, 0, 0, 1'b0, 1);
    check("single_gnt", 32'(hist[$]), 32'h4);
    txn(4'b1001, 0, 0, 1'b0, 0);
    check("ptr_after", 32'(hist[$]), 32'h8);
    txn(4'b0000, 0, 0, 1'b0, 0);

    // round robin with everyone requesting
    do_reset();
    hist.delete();
    for (int i = 0; i < R; i++) len_arr[i] = 1;
    repack();
    for (int t = 0; t < 5; t++) txn(4'b1111, 0, 0, 1'b0, 0);
    check("rr0", 32'(hist[0]), 32'h1);
    check("rr1", 32'(hist[1]), 32'h2);
    check("rr2", 32'(hist[2]), 32'h4);
    check("rr3", 32'(hist[3]), 32'h8);
    check("rr4", 32'(hist[4]), 32'h1);
    do_reset();

    // zero length, abort, withdrawal
    len_arr[1] = 0; repack();
    txn(4'b0010, 0, 0, 1'b0, 1);
    len_arr[0] = 10; repack();
    txn(4'b0001, 1, 3, 1'b0, 1);
    len_arr[2] = 6; repack();
    txn(4'b0100, 2, 2, 1'b0, 0);

    // reset while counting
    len_arr[3] = 10; repack();
    bus.req = 4'b1000;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.cnt != 8'd7 && n < 20);
    check("reach_cnt7", 32'(bus.cnt), 32'd7);
    do_reset();
    for (int i = 0; i < R; i++) len_arr[i] = 2;
    repack();
    txn(4'b1111, 0, 0, 1'b0, 0);
    check("restart_idx", 32'(hist[$]), 32'h1);

    // reset while in DONE
    bus.req = 4'b0001;
    repeat (3) tick();
    check("pre_rst_done", 32'(bus.done), 32'h1);
    do_reset();
    txn(4'b0110, 0, 0, 1'b0, 0);
    check("restart_idx2", 32'(hist[$]), 32'h2);
    do_reset();

    // len and other requests disturbed while running
    len_arr[1] = 4; repack();
    txn(4'b1010, 0, 0, 1'b1, 1);
    check("stir_win", 32'(hist[$]), 32'h2);
    txn(4'b0000, 0, 0, 1'b0, 0);
    check("pending_win", 32'(hist[$]), 32'h8);

    // randomized transactions
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < R; i++) len_arr[i] = $urandom_range(0, 12);
      repack();
      txn(R'($urandom), $urandom_range(0, 2), $urandom_range(0, 11),
          1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
